// File: rtl/pc_unit_pkg.sv
// Shared encodings and default constants for the pc_unit program-counter block.
// Optional return stack is enabled with the PC_UNIT_RAS_EN macro.
package pc_unit_pkg;

    typedef enum logic [2:0] {
        SEL_SEQ = 3'b000,
        SEL_BR  = 3'b001,
        SEL_J   = 3'b010,
        SEL_JAL = 3'b011,
        SEL_JR  = 3'b100
    } npc_sel_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/pc_unit_ras.sv
// Circular return-address stack: JAL pushes its link address, JR pops and compares.
// Instantiated by pc_unit only when PC_UNIT_RAS_EN is defined.
module pc_unit_ras #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_val,
    input  logic [ADDR_W-1:0] rs_val,
    output logic [ADDR_W-1:0] top_val,
    output logic              mispredict
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] stack_q [DEPTH];
    logic [PTR_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              mispredict_q, mispredict_d;
    logic              wr_en;

    always_comb begin
        top_d        = top_q;
        count_d      = count_q;
        mispredict_d = 1'b0;
        wr_en        = 1'b0;
        if (push) begin
            // Pointer wraps onto the oldest entry once full; count saturates.
            top_d   = top_q + PTR_W'(1);
            wr_en   = 1'b1;
            count_d = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + CNT_W'(1);
        end else if (pop && (count_q != '0)) begin
            top_d        = top_q - PTR_W'(1);
            count_d      = count_q - CNT_W'(1);
            mispredict_d = (stack_q[top_q] != rs_val);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q        <= '1;
            count_q      <= '0;
            mispredict_q <= 1'b0;
        end else begin
            top_q        <= top_d;
            count_q      <= count_d;
            mispredict_q <= mispredict_d;
        end
    end

    // NOTE: stack storage has no reset; count_q gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            stack_q[top_d] <= push_val;
        end
    end

    assign top_val    = (count_q != '0) ? stack_q[top_q] : '0;
    assign mispredict = mispredict_q;

endmodule

// File: rtl/pc_unit.sv
// Architectural PC register with next-PC selection, stall/pending-redirect FSM, exception/ERET and EPC.
// Define PC_UNIT_RAS_EN to add the return-address stack (ras_pred / ras_mispredict).
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [2:0]        npc_sel,
    input  logic              br_taken,
    input  logic [15:0]       imm16,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic              exc_req,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] epc,
    output logic              redirect,
    output logic              misalign_err,
    output logic [ADDR_W-1:0] ras_pred,
    output logic              ras_mispredict
);

    if (ADDR_W < 28 || RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_param_check
        $error("pc_unit: ADDR_W must be >= 28 and RAS_DEPTH a power of two >= 2");
    end

    localparam logic [ADDR_W-1:0] LOW28_MASK = ADDR_W'(28'hFFF_FFFF);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              redirect_q, redirect_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] pc_plus4_w, br_tgt, j_tgt, flow_tgt;
    logic              flow_req, jr_bad;

`ifdef PC_UNIT_RAS_EN
    logic ras_push, ras_pop;
`endif

    assign pc_plus4_w = pc_q + ADDR_W'(4);
    assign br_tgt     = pc_plus4_w + ({{(ADDR_W-16){imm16[15]}}, imm16} << 2);
    assign j_tgt      = (pc_plus4_w & ~LOW28_MASK) | ADDR_W'({imm26, 2'b00});

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        flow_req = 1'b0;
        jr_bad   = 1'b0;
        flow_tgt = pc_plus4_w;
        case (npc_sel)
            SEL_BR: begin
                flow_req = br_taken;
                flow_tgt = br_tgt;
            end
            SEL_J, SEL_JAL: begin
                flow_req = 1'b1;
                flow_tgt = j_tgt;
            end
            SEL_JR: begin
                flow_req = (rs_val[1:0] == 2'b00);
                jr_bad   = (rs_val[1:0] != 2'b00);
                flow_tgt = rs_val;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        pend_pc_d  = pend_pc_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;
`ifdef PC_UNIT_RAS_EN
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
`endif
        if (exc_req) begin
            pc_d       = EXC_VEC;
            epc_d      = pc_q;
            state_d    = ST_RUN;
            redirect_d = 1'b1;
        end else if (eret) begin
            pc_d       = epc_q;
            state_d    = ST_RUN;
            redirect_d = 1'b1;
        end else if (stall) begin
            // A misaligned JR is not captured here; it is re-evaluated once the stall drops.
            if (flow_req) begin
                pend_pc_d = flow_tgt;
                state_d   = ST_PEND;
            end
        end else if (state_q == ST_PEND) begin
            pc_d       = pend_pc_q;
            state_d    = ST_RUN;
            redirect_d = 1'b1;
        end else if (jr_bad) begin
            pc_d       = EXC_VEC;
            epc_d      = pc_q;
            misalign_d = 1'b1;
            redirect_d = 1'b1;
        end else if (flow_req) begin
            pc_d       = flow_tgt;
            redirect_d = 1'b1;
`ifdef PC_UNIT_RAS_EN
            ras_push   = (npc_sel == SEL_JAL);
            ras_pop    = (npc_sel == SEL_JR);
`endif
        end else begin
            pc_d = pc_plus4_w;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            epc_q      <= '0;
            pend_pc_q  <= '0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            pend_pc_q  <= pend_pc_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc           = pc_q;
    assign pc_plus4     = pc_plus4_w;
    assign epc          = epc_q;
    assign redirect     = redirect_q;
    assign misalign_err = misalign_q;

`ifdef PC_UNIT_RAS_EN
    pc_unit_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (ras_push),
        .pop        (ras_pop),
        .push_val   (pc_plus4_w),
        .rs_val     (rs_val),
        .top_val    (ras_pred),
        .mispredict (ras_mispredict)
    );
`else
    assign ras_pred       = '0;
    assign ras_mispredict = 1'b0;
`endif

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the combinational next-PC logic of the MIPS core.
- Owns the architectural PC register and computes the next PC for sequential, branch, J/JAL and JR flow.
- Adds stall handling with a pending-redirect buffer, an exception/ERET path with an EPC register, and JR target-misalignment detection.
- Sits between the IF stage (drives the I-mem address) and ID/EX, which supply select, condition and operands.

Parameters:
- ADDR_W, 32: PC/address width, ≥ 28.
- RESET_PC, 32'h0000_3000: PC value after reset.
- EXC_VEC, 32'h0000_4180: exception handler address.
- RAS_DEPTH, 4: return-stack entries, power of two (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold PC (hazard/memory wait)
- npc_sel  in  3  000 SEQ, 001 BR, 010 J, 011 JAL, 100 JR; others act as SEQ
- br_taken  in  1  branch condition, qualifies BR
- imm16  in  16  branch offset in words
- imm26  in  26  jump index
- rs_val  in  ADDR_W  JR target
- exc_req  in  1  take exception
- eret  in  1  return from exception
- pc  out  ADDR_W  current PC
- pc_plus4  out  ADDR_W  pc+4, used as link address
- epc  out  ADDR_W  saved exception PC
- redirect  out  1  one-cycle flush pulse on any non-sequential PC update
- misalign_err  out  1  one-cycle pulse on a misaligned JR target
- ras_pred  out  ADDR_W  RAS top of stack (optional feature)
- ras_mispredict  out  1  RAS disagreed with rs_val (optional feature)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, epc=0, redirect=0, misalign_err=0, pending cleared, RAS emptied.
- Arithmetic: all additions are modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0.
- pc_plus4 is combinational: pc_plus4 = pc+4.
- Branch target: pc_plus4 + (sext(imm16)<<2).
- Jump target: {pc_plus4[ADDR_W-1:28], imm26, 2'b00}.
- JR target: rs_val.
- Next-PC priority, highest first:
  1. exc_req: pc←EXC_VEC, epc←pc.
  2. eret: pc←epc.
  3. JR with rs_val[1:0]≠0: misalign_err=1, pc←EXC_VEC, epc←pc.
  4. JR / J / JAL, or BR with br_taken=1: pc←target.
  5. Otherwise: pc←pc_plus4.
- redirect is registered and asserted the cycle after any non-sequential update (cases 1–4, or a pending-redirect release).
- exc_req and eret override stall and clear any pending redirect.
- FSM has two states, RUN and PEND.
  - RUN, stall=1, case-4 request: latch target into pend_pc, hold pc, go to PEND.
  - RUN, stall=1, no request: hold pc.
  - PEND, stall=1: hold pc; a new case-4 request overwrites pend_pc (latest wins).
  - PEND, stall=0: pc←pend_pc, go to RUN. npc_sel/br_taken are ignored that cycle because they belong to the same instruction.
  - A misaligned JR under stall is not held: it is evaluated when stall drops.
- Reset mid-PEND returns to RUN with pc=RESET_PC.

Optional Feature:
- Macro: PC_UNIT_RAS_EN.
- With the macro:
  - RAS_DEPTH-entry circular return stack.
  - JAL, when it takes effect (not stalled), pushes pc_plus4; on overflow the oldest entry is overwritten and the count saturates.
  - JR, when it takes effect, pops.
  - ras_mispredict pulses for one cycle if a pop from a non-empty stack returns a value ≠ rs_val.
  - Popping an empty stack gives no mispredict and the count stays 0.
  - ras_pred = top of stack, or 0 when empty.
- Without the macro: ras_pred=0 and ras_mispredict=0, and the ports remain present.

Decomposition:
- Package pc_unit_pkg: npc_sel encodings (SEL_SEQ, SEL_BR, SEL_J, SEL_JAL, SEL_JR), RUN/PEND state encoding, default EXC_VEC/RESET_PC constants.
- One sub-module, pc_unit_ras: the stack, instantiated only under PC_UNIT_RAS_EN.

Test Plan:
- Reset release, npc_sel=SEQ for 3 cycles → pc = 3000, 3004, 3008; redirect=0.
- pc=3010, BR, br_taken=1, imm16=16'hFFFC → pc=3004, redirect pulses next cycle. Same with br_taken=0 → pc=3014.
- stall=1 with J imm26=0x000_0100 held 3 cycles, then stall=0 → pc held at old value, then 0000_0400; exactly one redirect pulse.
- JR rs_val=0000_3002 at pc=3020 → misalign_err=1, pc=4180, epc=3020. Then eret → pc=3020.
- exc_req while stall=1 and PEND → pc=4180 next cycle, pending discarded; rst_n low mid-PEND → pc=3000 immediately.
- RAS enabled, depth 4: five nested JALs then five JRs with matching rs_val → first four pops no mispredict, fifth pop on empty stack → no mispredict; one deliberately wrong rs_val → ras_mispredict=1.
